tank_field_renderer: RTL and testbench



---
 rtl/tank_pkg.sv | 52 +++++
 rtl/vga_timing_gen.sv | 96 +++++++++
 rtl/tank_field_renderer.sv | 189 ++++++++++++++++++
 tb/tb_tank_field_renderer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// Shared types, constants and sprite geometry for the tank field renderer.
package tank_pkg;

    typedef enum logic [1:0] {
        HEAD_UP    = 2'd0,
        HEAD_DOWN  = 2'd1,
        HEAD_LEFT  = 2'd2,
        HEAD_RIGHT = 2'd3
    } heading_t;

    localparam int TILE = 10;

    // Index 0 is the leftmost entry; tank i is drawn in PALETTE[i].
    localparam logic [0:7][23:0] PALETTE = {
        24'hFF4040, 24'h40FF40, 24'h4040FF, 24'hFFFF40,
        24'hFF40FF, 24'h40FFFF, 24'hFFA000, 24'hFFFFFF
    };

    function automatic logic in_range(input logic [3:0] val, input logic [3:0] lo,
                                      input logic [3:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

    // Returns {barrel, body} for one sub-pixel of a tank tile.
    function automatic logic [1:0] shape_hit(input heading_t head, input logic [3:0] sx,
                                             input logic [3:0] sy);
        logic barrel;
        logic body;
        barrel = 1'b0;
        body   = 1'b0;
        case (head)
            HEAD_UP: begin
                barrel = in_range(sx, 4'd4, 4'd5) && in_range(sy, 4'd0, 4'd3);
                body   = in_range(sx, 4'd2, 4'd7) && in_range(sy, 4'd4, 4'd9);
            end
            HEAD_DOWN: begin
                barrel = in_range(sx, 4'd4, 4'd5) && in_range(sy, 4'd6, 4'd9);
                body   = in_range(sx, 4'd2, 4'd7) && in_range(sy, 4'd0, 4'd5);
            end
            HEAD_LEFT: begin
                barrel = in_range(sx, 4'd0, 4'd3) && in_range(sy, 4'd4, 4'd5);
                body   = in_range(sx, 4'd4, 4'd9) && in_range(sy, 4'd2, 4'd7);
            end
            HEAD_RIGHT: begin
                barrel = in_range(sx, 4'd6, 4'd9) && in_range(sy, 4'd4, 4'd5);
                body   = in_range(sx, 4'd0, 4'd5) && in_range(sy, 4'd2, 4'd7);
            end
        endcase
        return {barrel, body};
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Display timing: line/frame counters, raw sync/de, frame tick and tile-grid counters.
module vga_timing_gen
    import tank_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int XW       = $clog2(H_ACTIVE / TILE),
    parameter int YW       = $clog2(V_ACTIVE / TILE)
) (
    input  logic          clk_25m,
    input  logic          rst_n,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          frame_tick,
    output logic [XW-1:0] tile_x,
    output logic [YW-1:0] tile_y,
    output logic [3:0]    sub_x,
    output logic [3:0]    sub_y
);

    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW           = $clog2(H_TOTAL);
    localparam int VW           = $clog2(V_TOTAL);
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_last;
    logic          v_last;

    assign h_last = (h_cnt == HW'(H_TOTAL - 1));
    assign v_last = (v_cnt == VW'(V_TOTAL - 1));

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    // Tile counters track h_cnt/v_cnt so pixel (h,v) sees tile h/10 and sub-pixel h%10.
    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            sub_x  <= '0;
            tile_x <= '0;
        end else if (h_last) begin
            sub_x  <= '0;
            tile_x <= '0;
        end else if (sub_x == 4'd9) begin
            sub_x  <= '0;
            tile_x <= tile_x + XW'(1);
        end else begin
            sub_x <= sub_x + 4'd1;
        end
    end

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            sub_y  <= '0;
            tile_y <= '0;
        end else if (h_last) begin
            if (v_last) begin
                sub_y  <= '0;
                tile_y <= '0;
            end else if (sub_y == 4'd9) begin
                sub_y  <= '0;
                tile_y <= tile_y + YW'(1);
            end else begin
                sub_y <= sub_y + 4'd1;
            end
        end
    end

    assign hsync = (h_cnt >= HW'(H_SYNC_START) && h_cnt < HW'(H_SYNC_START + H_SYNC))
                   ? SYNC_POL : ~SYNC_POL;
    assign vsync = (v_cnt >= VW'(V_SYNC_START) && v_cnt < VW'(V_SYNC_START + V_SYNC))
                   ? SYNC_POL : ~SYNC_POL;
    assign de         = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
    assign frame_tick = (h_cnt == '0) && (v_cnt == VW'(V_ACTIVE));

endmodule

// File: rtl/tank_field_renderer.sv
// Tank game video pipeline: per-tank heading/position state and a two-stage sprite renderer.
module tank_field_renderer
    import tank_pkg::*;
#(
    parameter int          H_ACTIVE  = 640,
    parameter int          H_FP      = 16,
    parameter int          H_SYNC    = 96,
    parameter int          H_BP      = 48,
    parameter int          V_ACTIVE  = 480,
    parameter int          V_FP      = 10,
    parameter int          V_SYNC    = 2,
    parameter int          V_BP      = 33,
    parameter bit          SYNC_POL  = 1'b0,
    parameter int          NUM_TANKS = 5,
    parameter int          MOVE_DIV  = 1,
    parameter logic [23:0] BG_RGB    = 24'h000000
) (
    input  logic                   clk_25m,
    input  logic                   rst_n,
    input  logic [4*NUM_TANKS-1:0] dir_in,
    input  logic [NUM_TANKS-1:0]   tank_en,
    output logic [7:0]             red,
    output logic [7:0]             green,
    output logic [7:0]             blue,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   de,
    output logic                   frame_tick
);

    localparam int GRID_W = H_ACTIVE / TILE;
    localparam int GRID_H = V_ACTIVE / TILE;
    localparam int XW     = $clog2(GRID_W);
    localparam int YW     = $clog2(GRID_H);

    logic          raw_hsync;
    logic          raw_vsync;
    logic          raw_de;
    logic [XW-1:0] tile_x;
    logic [YW-1:0] tile_y;
    logic [3:0]    sub_x;
    logic [3:0]    sub_y;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_POL (SYNC_POL),
        .XW       (XW),
        .YW       (YW)
    ) u_timing (
        .clk_25m    (clk_25m),
        .rst_n      (rst_n),
        .hsync      (raw_hsync),
        .vsync      (raw_vsync),
        .de         (raw_de),
        .frame_tick (frame_tick),
        .tile_x     (tile_x),
        .tile_y     (tile_y),
        .sub_x      (sub_x),
        .sub_y      (sub_y)
    );

    logic [3:0] move_cnt;
    logic       move_now;

    assign move_now = frame_tick && (move_cnt == 4'd0);

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            move_cnt <= '0;
        end else if (frame_tick) begin
            move_cnt <= (move_cnt == 4'(MOVE_DIV - 1)) ? 4'd0 : move_cnt + 4'd1;
        end
    end

    logic [NUM_TANKS-1:0] hit;

    for (genvar i = 0; i < NUM_TANKS; i++) begin : g_tank
        logic [3:0]    slice;
        logic          one_hot;
        logic          one_hot_q;
        heading_t      slice_head;
        heading_t      head;
        logic [XW-1:0] pos_x;
        logic [YW-1:0] pos_y;

        assign slice   = dir_in[4*i +: 4];
        assign one_hot = $onehot(slice);

        always_comb begin
            slice_head = HEAD_RIGHT;
            if (slice[3]) begin
                slice_head = HEAD_UP;
            end else if (slice[2]) begin
                slice_head = HEAD_DOWN;
            end else if (slice[1]) begin
                slice_head = HEAD_LEFT;
            end
        end

        // The move reads the heading before this edge's load, so a same-cycle change waits a move.
        always_ff @(posedge clk_25m or negedge rst_n) begin
            if (!rst_n) begin
                one_hot_q <= 1'b0;
                head      <= HEAD_UP;
                pos_x     <= XW'(4 * i);
                pos_y     <= '0;
            end else begin
                one_hot_q <= one_hot;
                if (tank_en[i]) begin
                    if (one_hot) begin
                        head <= slice_head;
                    end
                    if (move_now && one_hot_q) begin
                        case (head)
                            HEAD_UP:    if (pos_y != '0) pos_y <= pos_y - YW'(1);
                            HEAD_DOWN:  if (pos_y != YW'(GRID_H - 1)) pos_y <= pos_y + YW'(1);
                            HEAD_LEFT:  if (pos_x != '0) pos_x <= pos_x - XW'(1);
                            HEAD_RIGHT: if (pos_x != XW'(GRID_W - 1)) pos_x <= pos_x + XW'(1);
                        endcase
                    end
                end
            end
        end

        assign hit[i] = tank_en[i] && (tile_x == pos_x) && (tile_y == pos_y)
                        && (shape_hit(head, sub_x, sub_y) != 2'b00);
    end

    logic [2:0] sel;

    always_comb begin
        sel = '0;
        for (int i = NUM_TANKS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel = 3'(i);
            end
        end
    end

    logic [NUM_TANKS-1:0] hit_q;
    logic [2:0]           sel_q;
    logic                 de_q;
    logic                 hsync_q;
    logic                 vsync_q;

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            hit_q   <= '0;
            sel_q   <= '0;
            de_q    <= 1'b0;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
        end else begin
            hit_q   <= hit;
            sel_q   <= sel;
            de_q    <= raw_de;
            hsync_q <= raw_hsync;
            vsync_q <= raw_vsync;
        end
    end

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            {red, green, blue} <= '0;
            de                 <= 1'b0;
            hsync              <= ~SYNC_POL;
            vsync              <= ~SYNC_POL;
        end else begin
            if (!de_q) begin
                {red, green, blue} <= '0;
            end else if (|hit_q) begin
                {red, green, blue} <= PALETTE[sel_q];
            end else begin
                {red, green, blue} <= BG_RGB;
            end
            de    <= de_q;
            hsync <= hsync_q;
            vsync <= vsync_q;
        end
    end

endmodule

// File: tb/tb_tank_field_renderer.sv
// Randomised scoreboard bench for tank_field_renderer in a reduced video mode.
module tb_tank_field_renderer;
    import tank_pkg::*;

    localparam int          HA   = 80;
    localparam int          HFP  = 2;
    localparam int          HS   = 4;
    localparam int          HBP  = 2;
    localparam int          VA   = 40;
    localparam int          VFP  = 1;
    localparam int          VS   = 2;
    localparam int          VBP  = 2;
    localparam int          HT   = HA + HFP + HS + HBP;
    localparam int          VT   = VA + VFP + VS + VBP;
    localparam int          FRAME = HT * VT;
    localparam int          NT   = 2;
    localparam int          MD   = 2;
    localparam bit          POL  = 1'b1;
    localparam logic [23:0] BG   = 24'h102030;
    localparam int          GW   = HA / 10;
    localparam int          GH   = VA / 10;

    logic            clk_25m = 1'b0;
    logic            rst_n;
    logic [4*NT-1:0] dir_in;
    logic [NT-1:0]   tank_en;
    logic [7:0]      red, green, blue;
    logic            hsync, vsync, de, frame_tick;

    typedef struct packed {
        logic [31:0] cyc;
        logic [23:0] rgb;
        logic        de;
        logic        hs;
        logic        vs;
        logic        tick;
    } exp_t;

    exp_t       sb[$];
    exp_t       pend[$];
    int         checks = 0;
    int         errors = 0;
    bit         checking = 1'b0;

    int         mx[NT];
    int         my[NT];
    int         mhead[NT];
    bit         mprev[NT];
    int         ticks;
    logic [3:0] cur_dir[NT];

    tank_field_renderer #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .SYNC_POL (POL), .NUM_TANKS (NT), .MOVE_DIV (MD), .BG_RGB (BG)
    ) dut (
        .clk_25m    (clk_25m),
        .rst_n      (rst_n),
        .dir_in     (dir_in),
        .tank_en    (tank_en),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .hsync      (hsync),
        .vsync      (vsync),
        .de         (de),
        .frame_tick (frame_tick)
    );

    always #5 clk_25m = ~clk_25m;

    function automatic bit in_rect(int sx, int sy, int x0, int x1, int y0, int y1);
        return sx >= x0 && sx <= x1 && sy >= y0 && sy <= y1;
    endfunction

    // Sprite = barrel rectangle plus body rectangle, chosen by heading 0..3 (up/down/left/right).
    function automatic bit sprite_px(int hd, int sx, int sy);
        case (hd)
            0:       return in_rect(sx, sy, 4, 5, 0, 3) || in_rect(sx, sy, 2, 7, 4, 9);
            1:       return in_rect(sx, sy, 4, 5, 6, 9) || in_rect(sx, sy, 2, 7, 0, 5);
            2:       return in_rect(sx, sy, 0, 3, 4, 5) || in_rect(sx, sy, 4, 9, 2, 7);
            default: return in_rect(sx, sy, 6, 9, 4, 5) || in_rect(sx, sy, 0, 5, 2, 7);
        endcase
    endfunction

    function automatic int dir_to_head(logic [3:0] d);
        case (d)
            4'b1000: return 0;
            4'b0100: return 1;
            4'b0010: return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [3:0] rand_dir();
        int         r;
        logic [3:0] multi[4];
        multi = '{4'b1010, 4'b0101, 4'b1100, 4'b0111};
        r = $urandom_range(0, 19);
        if (r < 14) return 4'b0001 << $urandom_range(0, 3);
        if (r < 17) return 4'b0000;
        return multi[$urandom_range(0, 3)];
    endfunction

    function automatic exp_t reset_entry();
        exp_t e;
        e     = '0;
        e.hs  = ~POL;
        e.vs  = ~POL;
        return e;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < NT; i++) begin
            mx[i]      = 4 * i;
            my[i]      = 0;
            mhead[i]   = 0;
            mprev[i]   = 1'b0;
            cur_dir[i] = 4'b0000;
        end
        ticks = 0;
        sb.delete();
        pend.delete();
        pend.push_back(reset_entry());
        pend.push_back(reset_entry());
    endtask

    // Phase 1: random directions and occasional enable toggles; phase 2: two tanks driven into one tile.
    task automatic apply_stimulus(input int phase, input int h, input int v);
        bit edge_cycle;
        int k;
        edge_cycle = (h == 0 && v == VA) || (h == HT - 1 && v == VA - 1);
        if (phase == 1) begin
            if ($urandom_range(0, 2999) == 0) begin
                k = $urandom_range(0, NT - 1);
                tank_en[k] = ~tank_en[k];
            end
            for (int i = 0; i < NT; i++) begin
                if ($urandom_range(0, 1999) == 0 || (edge_cycle && $urandom_range(0, 1) == 1))
                    cur_dir[i] = rand_dir();
            end
        end else begin
            cur_dir[0] = (ticks >= 3) ? 4'b1010 : 4'b0001;
            cur_dir[1] = (ticks >= 3) ? 4'b0000 : 4'b0010;
        end
        for (int i = 0; i < NT; i++) begin
            if (!tank_en[i]) cur_dir[i] = 4'b0000;
            dir_in[4*i +: 4] = cur_dir[i];
        end
    endtask

    task automatic model_step(input int n, input int phase);
        int   h, v;
        bit   tick;
        exp_t px;
        exp_t e;
        h    = n % HT;
        v    = (n / HT) % VT;
        tick = (h == 0 && v == VA);
        apply_stimulus(phase, h, v);

        px     = '0;
        px.de  = (h < HA) && (v < VA);
        px.hs  = (h >= HA + HFP && h < HA + HFP + HS) ? POL : ~POL;
        px.vs  = (v >= VA + VFP && v < VA + VFP + VS) ? POL : ~POL;
        px.rgb = '0;
        if (px.de) begin
            px.rgb = BG;
            for (int i = NT - 1; i >= 0; i--) begin
                if (tank_en[i] && h / 10 == mx[i] && v / 10 == my[i]
                    && sprite_px(mhead[i], h % 10, v % 10))
                    px.rgb = PALETTE[i];
            end
        end
        pend.push_back(px);
        e      = pend.pop_front();
        e.cyc  = n;
        e.tick = tick;
        sb.push_back(e);

        if (tick) begin
            if (ticks % MD == 0) begin
                for (int i = 0; i < NT; i++) begin
                    if (tank_en[i] && mprev[i]) begin
                        case (mhead[i])
                            0:       if (my[i] > 0) my[i]--;
                            1:       if (my[i] < GH - 1) my[i]++;
                            2:       if (mx[i] > 0) mx[i]--;
                            default: if (mx[i] < GW - 1) mx[i]++;
                        endcase
                    end
                end
            end
            ticks++;
        end
        for (int i = 0; i < NT; i++) begin
            if (tank_en[i] && $countones(cur_dir[i]) == 1) mhead[i] = dir_to_head(cur_dir[i]);
            mprev[i] = ($countones(cur_dir[i]) == 1);
        end
    endtask

    task automatic check_output(input exp_t e);
        checks++;
        if ({red, green, blue} !== e.rgb) begin
            errors++;
            $display("[TB] FAIL rgb cycle=%0d actual=%h required=%h", e.cyc, {red, green, blue}, e.rgb);
        end
        checks++;
        if ({de, hsync, vsync} !== {e.de, e.hs, e.vs}) begin
            errors++;
            $display("[TB] FAIL de_hs_vs cycle=%0d actual=%b required=%b", e.cyc,
                     {de, hsync, vsync}, {e.de, e.hs, e.vs});
        end
        checks++;
        if (frame_tick !== e.tick) begin
            errors++;
            $display("[TB] FAIL frame_tick cycle=%0d actual=%b required=%b", e.cyc, frame_tick, e.tick);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        logic [30:0] want;
        want = {24'h000000, 1'b0, ~POL, ~POL, 1'b0};
        checks++;
        if ({red, green, blue, de, hsync, vsync, frame_tick} !== want) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", tag,
                     {red, green, blue, de, hsync, vsync, frame_tick}, want);
        end
    endtask

    task automatic check_drained(input string tag);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=0", tag, sb.size());
        end
    endtask

    task automatic run_phase(input int phase, input int ncycles);
        reset_model();
        tank_en = '1;
        dir_in  = '0;
        check_reset_outputs(phase == 1 ? "reset_state" : "reset_hold");
        #2 rst_n = 1'b1;
        checking = 1'b1;
        for (int n = 0; n < ncycles; n++) begin
            if (n > 0) begin
                @(posedge clk_25m);
                #1;
            end
            model_step(n, phase);
        end
        @(posedge clk_25m);
        #1;
        checking = 1'b0;
        check_drained("scoreboard_drain");
    endtask

    initial begin
        forever begin
            @(negedge clk_25m);
            if (checking) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL scoreboard_underflow actual=empty required=entry");
                end else begin
                    check_output(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        dir_in  = '0;
        tank_en = '1;
        repeat (3) @(posedge clk_25m);
        run_phase(1, 10 * FRAME + 37);

        // Reset lands mid-line in the active area, where de and rgb are non-zero.
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("reset_midline");
        repeat (2) @(posedge clk_25m);
        run_phase(2, 6 * FRAME);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
